// File: rtl/param_counter.sv
// Modulo-MODULUS up/down counter with clear, clamped load and optional saturation.
// Also provides a combinational terminal count, a registered wrap pulse and a registered saturation flag.
module param_counter #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             up_dn,
  input  logic             sat,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap,
  output logic             at_lim
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  // Reject parameter sets the counter cannot represent.
  if (WIDTH < 1 || MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_param_check
    $error("param_counter: need WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
  end

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_LOAD  = 2'b10,
    OP_COUNT = 2'b11
  } op_t;

  op_t              op;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             at_lim_nxt;

  assign op     = op_t'(mode);
  assign at_top = (q == MAX_Q);
  assign at_bot = (q == '0);
  assign qb     = ~q;
  assign tc     = en && (op == OP_COUNT) && (up_dn ? at_top : at_bot);

  // Out-of-range load values saturate at the top of the count range.
  assign load_clamped = ({1'b0, load_val} >= EXT_W'(MODULUS)) ? MAX_Q : load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      wrap   <= 1'b0;
      at_lim <= 1'b0;
    end else begin
      q      <= q_nxt;
      wrap   <= wrap_nxt;
      at_lim <= at_lim_nxt;
    end
  end

  // Next-state: clear dominates en; counting wraps or saturates at the range limits.
  always_comb begin
    q_nxt      = q;
    wrap_nxt   = 1'b0;
    at_lim_nxt = at_lim;
    if (op == OP_CLEAR) begin
      q_nxt      = '0;
      at_lim_nxt = 1'b0;
    end else if (en) begin
      case (op)
        OP_LOAD: begin
          q_nxt      = load_clamped;
          at_lim_nxt = 1'b0;
        end
        OP_COUNT: begin
          if (up_dn) begin
            if (!at_top) begin
              q_nxt = q + WIDTH'(1);
            end else if (sat) begin
              at_lim_nxt = 1'b1;
            end else begin
              q_nxt    = '0;
              wrap_nxt = 1'b1;
            end
          end else begin
            if (!at_bot) begin
              q_nxt = q - WIDTH'(1);
            end else if (sat) begin
              at_lim_nxt = 1'b1;
            end else begin
              q_nxt    = MAX_Q;
              wrap_nxt = 1'b1;
            end
          end
        end
        default: begin
          q_nxt = q;
        end
      endcase
    end
    if (q_nxt != q) begin
      at_lim_nxt = 1'b0;
    end
  end

endmodule
